sd_cmd_responder: RTL and testbench



---
 rtl/sd_cmd_responder_if.sv | 47 ++++
 rtl/sd_cmd_responder.sv | 163 ++++++++++++++++
 tb/tb_sd_cmd_responder.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_responder_if.sv
// ----------------------------------------------------------------------------
// sd_cmd_responder_if
// Groups the CMD-line signals exchanged between an SD host command path and
// the card-side responder.
//   cmd_from_host : host -> card CMD line, idle high
//   card_status   : R1 status payload offered by the card model
//   cmd_to_host   : card -> host CMD line, idle high
//   cmd_index     : index of the last accepted command
//   cmd_arg       : argument of the last accepted command
//   cmd_valid     : one-cycle pulse, command accepted
//   crc_err       : one-cycle pulse, frame rejected
//   busy          : responder is not idle
// modport slave  : the responder side
// modport master : the host / card-model side driving the responder
// ----------------------------------------------------------------------------
interface sd_cmd_responder_if;
    logic        cmd_from_host;
    logic [31:0] card_status;
    logic        cmd_to_host;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_valid;
    logic        crc_err;
    logic        busy;

    modport slave (
        input  cmd_from_host,
        input  card_status,
        output cmd_to_host,
        output cmd_index,
        output cmd_arg,
        output cmd_valid,
        output crc_err,
        output busy
    );

    modport master (
        output cmd_from_host,
        output card_status,
        input  cmd_to_host,
        input  cmd_index,
        input  cmd_arg,
        input  cmd_valid,
        input  crc_err,
        input  busy
    );
endinterface

// File: rtl/sd_cmd_responder.sv
// ----------------------------------------------------------------------------
// sd_cmd_responder
// Card-side CMD-line responder. Deserialises a 48-bit host command frame,
// checks transmission bit, end bit and CRC7, publishes index/argument, and
// after NCR idle cycles serialises a 48-bit R1 response carrying card_status.
// Ports:
//   sd_clock : sole clock, rising edge
//   reset    : asynchronous reset, active low
//   bus      : sd_cmd_responder_if.slave (CMD lines, status, decoded fields,
//              cmd_valid / crc_err pulses, busy)
// Parameter:
//   NCR      : idle cycles between command end and response start (2..64)
// ----------------------------------------------------------------------------
module sd_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic                  sd_clock,
    input  logic                  reset,
    sd_cmd_responder_if.slave     bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_CHECK,
        S_WAIT,
        S_SEND
    } state_t;

    localparam logic [6:0] NCR_LAST = 7'(NCR - 1);

    // Serial CRC7, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    endfunction

    state_t      r_state;
    logic [6:0]  r_cnt;
    logic [46:0] r_rx;       // frame bits 1..47; the start bit is implied
    logic [39:0] r_tx;       // response bits 0..39, MSB goes out first
    logic [6:0]  r_crc;      // shared: receive CRC, then transmit CRC
    logic        r_cmd_to_host;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;
    logic        r_cmd_valid;
    logic        r_crc_err;
    logic        r_busy;

    logic        w_frame_good;

    // r_rx[46] = transmission bit, r_rx[7:1] = received CRC, r_rx[0] = end bit
    assign w_frame_good = r_rx[46] && r_rx[0] && (r_rx[7:1] == r_crc);

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rx          <= '0;
            r_tx          <= '0;
            r_crc         <= '0;
            r_cmd_to_host <= 1'b1;
            r_cmd_index   <= '0;
            r_cmd_arg     <= '0;
            r_cmd_valid   <= 1'b0;
            r_crc_err     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_crc_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cmd_to_host <= 1'b1;
                    if (!bus.cmd_from_host) begin
                        // A zero start bit leaves a zero CRC, so the
                        // register simply starts from zero at bit 1.
                        r_state <= S_RECV;
                        r_cnt   <= 7'd1;
                        r_crc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_RECV: begin
                    r_rx <= {r_rx[45:0], bus.cmd_from_host};
                    if (r_cnt < 7'd40) begin
                        r_crc <= crc7_step(r_crc, bus.cmd_from_host);
                    end
                    if (r_cnt == 7'd47) begin
                        r_state <= S_CHECK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_CHECK: begin
                    r_cnt <= '0;
                    if (w_frame_good) begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_index <= r_rx[45:40];
                        r_cmd_arg   <= r_rx[39:8];
                        // card_status is captured here so later changes
                        // cannot disturb the response in flight.
                        r_tx        <= {2'b00, r_rx[45:40], bus.card_status};
                        r_crc       <= '0;
                        r_state     <= S_WAIT;
                    end else begin
                        r_crc_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == NCR_LAST) begin
                        // This edge drives response bit 0 (the start bit).
                        r_state       <= S_SEND;
                        r_cmd_to_host <= r_tx[39];
                        r_crc         <= crc7_step(r_crc, r_tx[39]);
                        r_tx          <= {r_tx[38:0], 1'b0};
                        r_cnt         <= 7'd1;
                    end else begin
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                S_SEND: begin
                    // r_cnt is the index of the bit driven on this edge.
                    if (r_cnt == 7'd48) begin
                        r_state       <= S_IDLE;
                        r_cmd_to_host <= 1'b1;
                        r_busy        <= 1'b0;
                        r_cnt         <= '0;
                    end else begin
                        if (r_cnt < 7'd40) begin
                            r_cmd_to_host <= r_tx[39];
                            r_crc         <= crc7_step(r_crc, r_tx[39]);
                            r_tx          <= {r_tx[38:0], 1'b0};
                        end else if (r_cnt < 7'd47) begin
                            r_cmd_to_host <= r_crc[6];
                            r_crc         <= {r_crc[5:0], 1'b0};
                        end else begin
                            r_cmd_to_host <= 1'b1;
                        end
                        r_cnt <= r_cnt + 7'd1;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_cmd_to_host <= 1'b1;
                    r_busy        <= 1'b0;
                    r_cnt         <= '0;
                end
            endcase
        end
    end

    assign bus.cmd_to_host = r_cmd_to_host;
    assign bus.cmd_index   = r_cmd_index;
    assign bus.cmd_arg     = r_cmd_arg;
    assign bus.cmd_valid   = r_cmd_valid;
    assign bus.crc_err     = r_crc_err;
    assign bus.busy        = r_busy;

endmodule

// File: tb/tb_sd_cmd_responder.sv
`timescale 1ns/1ps
module tb_sd_cmd_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_cmd_responder_if bus2();
    sd_cmd_responder_if bus64();

    sd_cmd_responder #(.NCR(2)) dut (
        .sd_clock (clk),
        .reset    (rst_n),
        .bus      (bus2)
    );

    sd_cmd_responder #(.NCR(64)) dut64 (
        .sd_clock (clk),
        .reset    (rst_n),
        .bus      (bus64)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [5:0]  exp_idx = '0;
    logic [31:0] exp_arg = '0;

    // ---------------- reference model ----------------
    // CRC7 as the remainder of data(x) * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] data);
        logic [46:0] v;
        logic [46:0] g;
        v = {data, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) begin
                g = 47'h89 << (i - 7);
                v = v ^ g;
            end
        end
        return v[6:0];
    endfunction

    function automatic logic [47:0] ref_cmd(input logic [5:0] idx, input logic [31:0] arg);
        return {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
    endfunction

    function automatic logic [47:0] ref_resp(input logic [5:0] idx, input logic [31:0] st);
        return {2'b00, idx, st, ref_crc7({2'b00, idx, st}), 1'b1};
    endfunction

    function automatic bit ref_good(input logic [47:0] f);
        return (f[47] == 1'b0) && (f[46] == 1'b1) && (f[0] == 1'b1) &&
               (f[7:1] == ref_crc7(f[47:8]));
    endfunction

    // ---------------- DUT access ----------------
    function automatic logic line_out(input bit sel);
        return sel ? bus64.cmd_to_host : bus2.cmd_to_host;
    endfunction
    function automatic logic busy_out(input bit sel);
        return sel ? bus64.busy : bus2.busy;
    endfunction
    function automatic logic valid_out(input bit sel);
        return sel ? bus64.cmd_valid : bus2.cmd_valid;
    endfunction
    function automatic logic err_out(input bit sel);
        return sel ? bus64.crc_err : bus2.crc_err;
    endfunction
    function automatic logic [5:0] idx_out(input bit sel);
        return sel ? bus64.cmd_index : bus2.cmd_index;
    endfunction
    function automatic logic [31:0] arg_out(input bit sel);
        return sel ? bus64.cmd_arg : bus2.cmd_arg;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input bit sel, input logic b);
        if (sel) bus64.cmd_from_host = b;
        else     bus2.cmd_from_host = b;
    endtask

    // Drives a frame MSB first; returns just after the edge sampling the end bit.
    task automatic send_frame(input bit sel, input logic [47:0] f);
        for (int k = 47; k >= 0; k--) begin
            drive_line(sel, f[k]);
            tick();
        end
        drive_line(sel, 1'b1);
    endtask

    // Called just after edge S+48. start_off = edges after S+48 at which the
    // first low bit was seen (-1 on timeout). Line held low for 'jam' edges.
    task automatic capture_resp(input bit sel, input int jam, output logic [47:0] resp,
                                output int start_off, output bit pulse_seen);
        int m;
        resp = '1;
        start_off = -1;
        pulse_seen = 1'b0;
        m = 0;
        while (start_off < 0 && m < 200) begin
            drive_line(sel, (m < jam) ? 1'b0 : 1'b1);
            tick();
            m++;
            if (valid_out(sel) || err_out(sel)) pulse_seen = 1'b1;
            if (line_out(sel) == 1'b0) start_off = m;
        end
        if (start_off >= 0) begin
            resp[47] = 1'b0;
            for (int k = 46; k >= 0; k--) begin
                drive_line(sel, (m < jam) ? 1'b0 : 1'b1);
                tick();
                m++;
                if (valid_out(sel) || err_out(sel)) pulse_seen = 1'b1;
                resp[k] = line_out(sel);
            end
        end
        drive_line(sel, 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        bus2.cmd_from_host = 1'b1;
        bus64.cmd_from_host = 1'b1;
        bus2.card_status = '0;
        bus64.card_status = '0;
        repeat (3) tick();
        n_checks++;
        if ({bus2.cmd_to_host, bus2.busy, bus2.cmd_valid, bus2.crc_err, bus2.cmd_index, bus2.cmd_arg}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0})
            $display("FAIL reset_state: got line=%b busy=%b v=%b e=%b idx=%0d arg=%h want 1 0 0 0 0 0",
                     bus2.cmd_to_host, bus2.busy, bus2.cmd_valid, bus2.crc_err, bus2.cmd_index, bus2.cmd_arg);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bus2.cmd_to_host !== 1'b1 || bus2.busy !== 1'b0 || bus2.cmd_valid !== 1'b0 ||
                bus2.crc_err !== 1'b0 || bus64.cmd_to_host !== 1'b1 || bus64.busy !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL idle_quiet: got %0d bad cycles want 0", bad);
        else n_pass++;
    endtask

    task automatic test_cmd0();
        logic [47:0] resp;
        int off;
        bit ps;
        bus2.card_status = 32'h0000_0900;
        send_frame(1'b0, 48'h40_0000_0000_95);
        tick();  // S+48
        n_checks++;
        if ({bus2.cmd_valid, bus2.crc_err} !== 2'b10)
            $display("FAIL cmd0_pulse: got v=%b e=%b want 1 0", bus2.cmd_valid, bus2.crc_err);
        else n_pass++;
        n_checks++;
        if ({bus2.cmd_index, bus2.cmd_arg} !== {6'd0, 32'd0})
            $display("FAIL cmd0_fields: got idx=%0d arg=%h want 0 0", bus2.cmd_index, bus2.cmd_arg);
        else n_pass++;
        exp_idx = 6'd0;
        exp_arg = 32'd0;
        capture_resp(1'b0, 0, resp, off, ps);
        n_checks++;
        if (off !== 2) $display("FAIL cmd0_start: got S+48+%0d want S+48+2", off);
        else n_pass++;
        n_checks++;
        if (resp !== ref_resp(6'd0, 32'h0000_0900))
            $display("FAIL cmd0_resp: got %h want %h", resp, ref_resp(6'd0, 32'h0000_0900));
        else n_pass++;
        n_checks++;
        if (ps !== 1'b0) $display("FAIL cmd0_single_pulse: got extra pulse=%b want 0", ps);
        else n_pass++;
        tick();  // S+96+NCR
        n_checks++;
        if ({bus2.cmd_to_host, bus2.busy} !== 2'b10)
            $display("FAIL cmd0_end: got line=%b busy=%b want 1 0", bus2.cmd_to_host, bus2.busy);
        else n_pass++;
    endtask

    task automatic test_cmd8_cmd17();
        logic [47:0] frames [2];
        logic [47:0] resp;
        logic [31:0] st;
        int off;
        bit ps;
        frames[0] = 48'h48_0000_01AA_87;
        frames[1] = 48'h51_0000_0000_55;
        for (int i = 0; i < 2; i++) begin
            st = $urandom;
            bus2.card_status = st;
            send_frame(1'b0, frames[i]);
            tick();  // S+48
            // Changing the status after the CHECK edge must not reach the wire.
            bus2.card_status = ~st;
            n_checks++;
            if ({bus2.cmd_valid, bus2.cmd_index, bus2.cmd_arg} !== {1'b1, frames[i][45:40], frames[i][39:8]})
                $display("FAIL cmd%0d_decode: got v=%b idx=%0d arg=%h want 1 %0d %h", frames[i][45:40],
                         bus2.cmd_valid, bus2.cmd_index, bus2.cmd_arg, frames[i][45:40], frames[i][39:8]);
            else n_pass++;
            exp_idx = frames[i][45:40];
            exp_arg = frames[i][39:8];
            capture_resp(1'b0, 0, resp, off, ps);
            n_checks++;
            if (off !== 2 || resp !== ref_resp(frames[i][45:40], st))
                $display("FAIL cmd%0d_resp: got off=%0d %h want off=2 %h", frames[i][45:40],
                         off, resp, ref_resp(frames[i][45:40], st));
            else n_pass++;
            tick();
            n_checks++;
            if ({bus2.cmd_to_host, bus2.busy} !== 2'b10)
                $display("FAIL cmd%0d_end: got line=%b busy=%b want 1 0", frames[i][45:40],
                         bus2.cmd_to_host, bus2.busy);
            else n_pass++;
        end
    endtask

    task automatic test_bad_frames();
        logic [47:0] resp;
        int off;
        bit ps;
        int bad;
        // Wrong CRC byte.
        send_frame(1'b0, 48'h40_0000_0000_97);
        tick();  // S+48
        n_checks++;
        if ({bus2.crc_err, bus2.cmd_valid, bus2.cmd_index, bus2.cmd_arg} !== {2'b10, exp_idx, exp_arg})
            $display("FAIL badcrc_reject: got e=%b v=%b idx=%0d arg=%h want 1 0 %0d %h",
                     bus2.crc_err, bus2.cmd_valid, bus2.cmd_index, bus2.cmd_arg, exp_idx, exp_arg);
        else n_pass++;
        tick();  // S+49
        n_checks++;
        if ({bus2.crc_err, bus2.busy} !== 2'b00)
            $display("FAIL badcrc_pulse_end: got e=%b busy=%b want 0 0", bus2.crc_err, bus2.busy);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (bus2.cmd_to_host !== 1'b1 || bus2.busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL badcrc_no_resp: got %0d active cycles want 0", bad);
        else n_pass++;
        // Good CRC, end bit zero; next start bit lands on S+49.
        send_frame(1'b0, 48'h40_0000_0000_94);
        tick();  // S+48
        n_checks++;
        if ({bus2.crc_err, bus2.cmd_valid, bus2.cmd_index, bus2.cmd_arg} !== {2'b10, exp_idx, exp_arg})
            $display("FAIL badend_reject: got e=%b v=%b idx=%0d arg=%h want 1 0 %0d %h",
                     bus2.crc_err, bus2.cmd_valid, bus2.cmd_index, bus2.cmd_arg, exp_idx, exp_arg);
        else n_pass++;
        bus2.card_status = 32'h0000_0120;
        send_frame(1'b0, 48'h48_0000_01AA_87);
        tick();
        n_checks++;
        if ({bus2.cmd_valid, bus2.cmd_index, bus2.cmd_arg} !== {1'b1, 6'd8, 32'h0000_01AA})
            $display("FAIL after_bad_accept: got v=%b idx=%0d arg=%h want 1 8 000001aa",
                     bus2.cmd_valid, bus2.cmd_index, bus2.cmd_arg);
        else n_pass++;
        exp_idx = 6'd8;
        exp_arg = 32'h0000_01AA;
        capture_resp(1'b0, 0, resp, off, ps);
        n_checks++;
        if (off !== 2 || resp !== ref_resp(6'd8, 32'h0000_0120))
            $display("FAIL after_bad_resp: got off=%0d %h want off=2 %h", off, resp,
                     ref_resp(6'd8, 32'h0000_0120));
        else n_pass++;
        tick();
    endtask

    task automatic test_collision();
        logic [47:0] resp;
        logic [31:0] st;
        int off;
        bit ps;
        st = $urandom;
        bus2.card_status = st;
        send_frame(1'b0, 48'h51_0000_0000_55);
        tick();  // S+48
        exp_idx = 6'd17;
        exp_arg = 32'd0;
        // Line held low from S+49 (WAIT) into the early SEND cycles.
        capture_resp(1'b0, 10, resp, off, ps);
        n_checks++;
        if (off !== 2 || resp !== ref_resp(6'd17, st))
            $display("FAIL collide_resp: got off=%0d %h want off=2 %h", off, resp, ref_resp(6'd17, st));
        else n_pass++;
        n_checks++;
        if (ps !== 1'b0) $display("FAIL collide_pulse: got pulse=%b want 0", ps);
        else n_pass++;
        repeat (6) tick();
        n_checks++;
        if ({bus2.busy, bus2.cmd_to_host, bus2.cmd_index} !== {1'b0, 1'b1, 6'd17})
            $display("FAIL collide_not_queued: got busy=%b line=%b idx=%0d want 0 1 17",
                     bus2.busy, bus2.cmd_to_host, bus2.cmd_index);
        else n_pass++;
    endtask

    task automatic test_reset_mid_send();
        logic [47:0] want;
        logic [47:0] resp;
        int off;
        bit ps;
        bus2.card_status = 32'h0000_0900;
        want = ref_resp(6'd17, 32'h0000_0900);
        send_frame(1'b0, 48'h51_0000_0000_55);
        tick();            // S+48
        repeat (2) tick(); // start bit
        repeat (20) tick();// bit 20
        n_checks++;
        if (bus2.cmd_to_host !== want[47 - 20])
            $display("FAIL send_bit20: got %b want %b", bus2.cmd_to_host, want[47 - 20]);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus2.cmd_to_host, bus2.busy, bus2.cmd_index, bus2.cmd_arg} !== {2'b10, 6'd0, 32'd0})
            $display("FAIL async_reset: got line=%b busy=%b idx=%0d arg=%h want 1 0 0 0",
                     bus2.cmd_to_host, bus2.busy, bus2.cmd_index, bus2.cmd_arg);
        else n_pass++;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        exp_idx = 6'd0;
        exp_arg = 32'd0;
        send_frame(1'b0, 48'h40_0000_0000_95);
        tick();
        n_checks++;
        if ({bus2.cmd_valid, bus2.crc_err, bus2.cmd_index} !== {2'b10, 6'd0})
            $display("FAIL post_reset_cmd0: got v=%b e=%b idx=%0d want 1 0 0",
                     bus2.cmd_valid, bus2.crc_err, bus2.cmd_index);
        else n_pass++;
        capture_resp(1'b0, 0, resp, off, ps);
        n_checks++;
        if (off !== 2 || resp !== ref_resp(6'd0, 32'h0000_0900))
            $display("FAIL post_reset_resp: got off=%0d %h want off=2 %h", off, resp,
                     ref_resp(6'd0, 32'h0000_0900));
        else n_pass++;
        tick();
    endtask

    task automatic test_ncr64();
        logic [47:0] resp;
        logic [31:0] st;
        int off;
        bit ps;
        st = $urandom;
        bus64.card_status = st;
        send_frame(1'b1, 48'h48_0000_01AA_87);
        tick();  // S+48
        n_checks++;
        if ({bus64.cmd_valid, bus64.cmd_index, bus64.cmd_arg} !== {1'b1, 6'd8, 32'h0000_01AA})
            $display("FAIL ncr64_decode: got v=%b idx=%0d arg=%h want 1 8 000001aa",
                     bus64.cmd_valid, bus64.cmd_index, bus64.cmd_arg);
        else n_pass++;
        capture_resp(1'b1, 0, resp, off, ps);
        n_checks++;
        if (off !== 64) $display("FAIL ncr64_start: got S+48+%0d want S+48+64", off);
        else n_pass++;
        n_checks++;
        if (resp !== ref_resp(6'd8, st))
            $display("FAIL ncr64_resp: got %h want %h", resp, ref_resp(6'd8, st));
        else n_pass++;
        tick();
        n_checks++;
        if ({bus64.cmd_to_host, bus64.busy} !== 2'b10)
            $display("FAIL ncr64_end: got line=%b busy=%b want 1 0", bus64.cmd_to_host, bus64.busy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [47:0] f;
        logic [47:0] resp;
        logic [31:0] st;
        logic [5:0]  idx;
        logic [31:0] arg;
        int mode;
        int pos;
        int off;
        bit ps;
        bit good;
        for (int it = 0; it < 12; it++) begin
            idx  = 6'($urandom_range(0, 63));
            arg  = $urandom;
            st   = $urandom;
            f    = ref_cmd(idx, arg);
            mode = $urandom_range(0, 3);
            if (mode == 1) begin
                pos = $urandom_range(1, 46);
                f[pos] = ~f[pos];
            end else if (mode == 2) begin
                f[46] = 1'b0;
            end else if (mode == 3) begin
                f[0] = 1'b0;
            end
            good = ref_good(f);
            bus2.card_status = st;
            send_frame(1'b0, f);
            tick();  // S+48
            if (good) begin
                exp_idx = f[45:40];
                exp_arg = f[39:8];
            end
            n_checks++;
            if ({bus2.cmd_valid, bus2.crc_err, bus2.cmd_index, bus2.cmd_arg} !== {good, !good, exp_idx, exp_arg})
                $display("FAIL rand%0d_check: got v=%b e=%b idx=%0d arg=%h want %b %b %0d %h", it,
                         bus2.cmd_valid, bus2.crc_err, bus2.cmd_index, bus2.cmd_arg,
                         good, !good, exp_idx, exp_arg);
            else n_pass++;
            if (good) begin
                bus2.card_status = $urandom;
                capture_resp(1'b0, 0, resp, off, ps);
                n_checks++;
                if (off !== 2 || resp !== ref_resp(f[45:40], st))
                    $display("FAIL rand%0d_resp: got off=%0d %h want off=2 %h", it, off, resp,
                             ref_resp(f[45:40], st));
                else n_pass++;
                tick();
            end else begin
                tick();  // S+49
            end
            n_checks++;
            if ({bus2.cmd_to_host, bus2.busy} !== 2'b10)
                $display("FAIL rand%0d_idle: got line=%b busy=%b want 1 0", it, bus2.cmd_to_host, bus2.busy);
            else n_pass++;
            repeat ($urandom_range(0, 5)) tick();
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle();
        test_cmd0();
        test_cmd8_cmd17();
        test_bad_frames();
        test_collision();
        test_reset_mid_send();
        test_ncr64();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
